// File: rtl/hi_lo_muldiv_if.sv
// Port bundle for the HI/LO multiply/divide unit: request side from EX, HI/LO/status back out.
// Start is a one-cycle request that is accepted only on an edge where Busy=0; Done is a one-cycle
// pulse on the cycle Hi/Lo first show a new result, and Busy is the registered stall indication.
interface hi_lo_muldiv_if;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        WriteHi;
  logic        WriteLo;
  logic [31:0] WrData;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        dbg_run;
  logic [4:0]  dbg_count;

  modport master (
    output Start, Op, A, B, WriteHi, WriteLo, WrData,
    input  Hi, Lo, Busy, Done, dbg_run, dbg_count
  );

  modport slave (
    input  Start, Op, A, B, WriteHi, WriteLo, WrData,
    output Hi, Lo, Busy, Done, dbg_run, dbg_count
  );
endinterface

// File: rtl/hi_lo_muldiv.sv
// Iterative 32-cycle multiply/divide unit owning the architectural HI and LO registers.
// Signed ops run on magnitudes and are sign-corrected on the final iteration.
module hi_lo_muldiv (
  input  logic           Clk,
  input  logic           Reset,
  hi_lo_muldiv_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic        div0;
  logic [31:0] a_raw;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] mshift;
  logic [63:0] work;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        done_r;

  logic        signed_op;
  logic        a_sgn;
  logic        b_sgn;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [63:0] work_nxt;
  logic [63:0] prod_fix;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  always_comb begin
    signed_op = ~bus.Op[0];
    a_sgn     = signed_op & bus.A[31];
    b_sgn     = signed_op & bus.B[31];
    a_abs     = a_sgn ? (~bus.A + 32'd1) : bus.A;
    b_abs     = b_sgn ? (~bus.B + 32'd1) : bus.B;

    // Multiply: add multiplicand into the upper half, then shift the whole product right.
    mul_sum = {1'b0, work[63:32]} + {1'b0, (mshift[0] ? mag_a : 32'd0)};
    // Divide: partial remainder lives in work[63:32], quotient bits shift into work[31:0].
    rem_sh  = {work[63:32], mshift[31]};
    diff    = rem_sh - {1'b0, mag_b};

    if (is_div) begin
      if (!diff[32]) work_nxt = {diff[31:0], work[30:0], 1'b1};
      else           work_nxt = {rem_sh[31:0], work[30:0], 1'b0};
    end else begin
      work_nxt = {mul_sum, work[31:1]};
    end

    prod_fix = neg_q ? (~work_nxt + 64'd1) : work_nxt;
    q_fix    = neg_q ? (~work_nxt[31:0] + 32'd1) : work_nxt[31:0];
    r_fix    = neg_r ? (~work_nxt[63:32] + 32'd1) : work_nxt[63:32];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      a_raw  <= 32'd0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      mshift <= 32'd0;
      work   <= 64'd0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.WriteHi) hi_r <= bus.WrData;
          if (bus.WriteLo) lo_r <= bus.WrData;
          if (bus.Start) begin
            is_div <= bus.Op[1];
            neg_q  <= a_sgn ^ b_sgn;
            neg_r  <= a_sgn;
            div0   <= bus.Op[1] && (bus.B == 32'd0);
            a_raw  <= bus.A;
            mag_a  <= a_abs;
            mag_b  <= b_abs;
            // Shifter holds the multiplier for MULT and the dividend for DIV.
            mshift <= bus.Op[1] ? a_abs : b_abs;
            work   <= 64'd0;
            cnt    <= 5'd0;
            state  <= RUN;
          end
        end
        RUN: begin
          work   <= work_nxt;
          mshift <= is_div ? (mshift << 1) : (mshift >> 1);
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state  <= IDLE;
            done_r <= 1'b1;
            if (div0) begin
              hi_r <= a_raw;
              lo_r <= 32'hFFFF_FFFF;
            end else if (is_div) begin
              hi_r <= r_fix;
              lo_r <= q_fix;
            end else begin
              hi_r <= prod_fix[63:32];
              lo_r <= prod_fix[31:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Hi        = hi_r;
  assign bus.Lo        = lo_r;
  assign bus.Busy      = (state == RUN);
  assign bus.Done      = done_r;
  assign bus.dbg_run   = (state == RUN);
  assign bus.dbg_count = cnt;

endmodule
